uart_receive_param: RTL and testbench
=====================================

// Module: uart_receive_param
// PURPOSE
//  Parametrised UART receiver. Successor to the fixed 8E1, 20-clk/bit receiver.
//  Configurable data width, parity mode, stop-bit count and bit period.
//  Adds a 2-flop input synchroniser, 3-sample majority vote and start-glitch rejection.
//  Reports parity, framing and overrun errors. Sits between the board RX pin and the command/data consumer.
// PARAMETERS
//  CLKS_PER_BIT  20  clk cycles per UART bit; legal range >= 8
//  DATA_BITS     8   payload bits per frame; legal range 5..9; sent LSB first
//  PARITY        1   parity mode: 0 none, 1 even, 2 odd
//  STOP_BITS     1   stop bits per frame; legal values 1 or 2
// PORTS
//  clk          in   1          system clock
//  reset        in   1          asynchronous, active-low (0 = reset)
//  rx_i         in   1          serial line, idle high, asynchronous to clk
//  data         out  DATA_BITS  last received payload
//  ready        out  1          payload valid; held until reset_ready
//  reset_ready  in   1          consumer ack, 1-clk pulse; clears ready/overrun
//  parity_err   out  1          parity mismatch on frame currently in data
//  frame_err    out  1          a stop bit sampled 0 on frame currently in data
//  overrun      out  1          frame completed while ready=1; sticky until ack
//  busy         out  1          1 in any state other than IDLE
// BEHAVIOUR
//  Reset values: data=0, ready=0, parity_err=0, frame_err=0, overrun=0, busy=0.
//  Reset state: FSM=IDLE, synchroniser flops=1.
//  Reset mid-frame aborts the frame with no output update.
//  rx_i passes through 2 flops (rx_s). Bit sample = majority of rx_s at counts MID-1, MID, MID+1.
//  MID = CLKS_PER_BIT/2. The bit counter runs 0..CLKS_PER_BIT-1, then wraps.
//  FSM states and transitions:
//   IDLE:      rx_s 1->0 edge -> START, counter cleared.
//   START:     at MID+1, vote=1 -> IDLE (glitch, nothing reported); vote=0 -> DATA at bit end.
//   DATA:      shift vote in LSB-first; after DATA_BITS bits -> PARITY (PARITY!=0) else STOP.
//   PARITY:    expected bit = ^payload (even) or ~^payload (odd).
//   STOP:      sample each stop bit. At MID+1 of the last stop bit, commit.
//              Commit order: data, parity_err, frame_err, ready=1 all in the next clk (latency 1).
//              If no stop bit was 0 -> IDLE; else -> WAIT_IDLE.
//              Commit happens mid-stop-bit: back-to-back frames are supported.
//   WAIT_IDLE: stay until rx_s=1 for one full CLKS_PER_BIT, then IDLE. Covers break / line stuck low.
//  Frames with errors are still committed; the error flags describe that frame only.
//  Commit with ready=1 and no ack: data is overwritten, overrun<=1.
//  Commit in the same clk as reset_ready: ready stays 1, overrun<=0; the new frame wins.
//  reset_ready while ready=0: no effect.
//  Error flags are updated only on commit; ack does not clear them.
// STRUCTURE
//  Shared package uart_pkg: PARITY_NONE/EVEN/ODD constants; FSM state encoding.
//   The transmitter successor reuses this package.
//  Sub-module uart_bit_sampler: synchroniser, per-bit counter, majority vote.
//   Outputs rx_s, sample_valid (1 clk at MID+1), bit_end (count wrap).
//   Inputs restart (clears the counter on start detect).
//  Top level: FSM, shift register, parity accumulator, output/flag registers.
// TESTING  (clk 20 ns, defaults unless stated; bit period 400 ns)
//  1 Frames 0x1D, 0xE2, 0xFF, all even parity, stop=1, back to back:
//    -> 3 commits with data=0x1D, 0xE2, 0xFF; all error flags 0.
//    -> Ack each frame 100 ns after ready.
//  2 Same stream, no acks:
//    -> data=0xFF, ready=1 held; overrun=1 after the 2nd commit.
//  3 Send 0x1D with parity bit 1:
//    -> parity_err=1, data=0x1D.
//    -> Next clean frame clears parity_err.
//  4 Stop bit 0, then line held low 2000 ns:
//    -> frame_err=1; busy=1 until 400 ns after the line returns high.
//    -> No extra commit occurs.
//  5 Glitches:
//    -> 60 ns low pulse on idle line: no commit, busy returns 0 by 240 ns.
//    -> 20 ns spike inside a data bit: payload unaffected.
//  6 Parameter and reset cases:
//    -> PARITY=0, STOP_BITS=2, DATA_BITS=7, CLKS_PER_BIT=16: 0x55 received correctly.
//    -> reset asserted mid-DATA: all outputs 0; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART constants, FSM state encoding and majority-vote helper.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : uart_bit_sampler
// Brief  : RX synchroniser, per-bit counter and 3-sample majority vote.
// Rev    : 1.0  initial release
// ============================================================================
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    input  logic restart,
    output logic rx_s,
    output logic sample_valid,
    output logic sample_bit,
    output logic bit_end
);

    localparam int              c_CW     = $clog2(CLKS_PER_BIT);
    localparam int              c_MID    = CLKS_PER_BIT / 2;
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_MID_LO = c_CW'(c_MID - 1);
    localparam logic [c_CW-1:0] c_MID_C  = c_CW'(c_MID);
    localparam logic [c_CW-1:0] c_MID_HI = c_CW'(c_MID + 1);

    logic [1:0]      r_sync;
    logic [c_CW-1:0] r_cnt;
    logic            r_s_lo;
    logic            r_s_mid;

    // Synchroniser resets to idle-high so no false start edge follows reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_s_lo  <= 1'b1;
            r_s_mid <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx_i};
            if (restart || (r_cnt == c_LAST)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            if (r_cnt == c_MID_LO) r_s_lo  <= rx_s;
            if (r_cnt == c_MID_C)  r_s_mid <= rx_s;
        end
    end

    assign rx_s         = r_sync[1];
    assign sample_valid = (r_cnt == c_MID_HI);
    assign sample_bit   = majority3(r_s_lo, r_s_mid, rx_s);
    assign bit_end      = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_receive_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : uart_receive_param
// Brief  : Parametrised UART receiver with parity/framing/overrun reporting.
// Rev    : 1.0  initial release
// ============================================================================
module uart_receive_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 20,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    input  logic                 reset_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int              c_CW        = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      c_DATA_CNT  = 4'(DATA_BITS);
    localparam logic [3:0]      c_LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_t          r_state;
    logic                 r_rx_prev;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_idx;
    logic                 r_par_bad;
    logic                 r_stop_bad;
    logic [c_CW-1:0]      r_idle_cnt;

    logic w_rx_s;
    logic w_sample_valid;
    logic w_vote;
    logic w_bit_end;
    logic w_restart;
    logic w_commit;
    logic w_stop_fail;
    logic w_par_exp;

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx_i),
        .restart      (w_restart),
        .rx_s         (w_rx_s),
        .sample_valid (w_sample_valid),
        .sample_bit   (w_vote),
        .bit_end      (w_bit_end)
    );

    assign w_restart   = (r_state == ST_IDLE) & r_rx_prev & ~w_rx_s;
    assign w_commit    = (r_state == ST_STOP) & w_sample_valid & (r_bit_idx == c_LAST_STOP);
    assign w_stop_fail = r_stop_bad | ~w_vote;
    assign w_par_exp   = (PARITY == PARITY_ODD) ? ~^r_shift : ^r_shift;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rx_prev  <= 1'b1;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_idle_cnt <= '0;
            data       <= '0;
            ready      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;

            // A commit coinciding with an ack wins: ready stays set, overrun clears
            if (w_commit) begin
                data       <= r_shift;
                parity_err <= r_par_bad;
                frame_err  <= w_stop_fail;
                ready      <= 1'b1;
                overrun    <= ready & ~reset_ready;
            end else if (reset_ready && ready) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_restart) begin
                        r_state    <= ST_START;
                        r_bit_idx  <= '0;
                        r_par_bad  <= 1'b0;
                        r_stop_bad <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_sample_valid && w_vote) begin
                        r_state <= ST_IDLE;
                    end else if (w_bit_end) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_sample_valid) begin
                        r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end else if (w_bit_end && (r_bit_idx == c_DATA_CNT)) begin
                        r_bit_idx <= '0;
                        r_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (w_sample_valid) begin
                        r_par_bad <= w_vote ^ w_par_exp;
                    end else if (w_bit_end) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Committing mid-stop-bit leaves room for a back-to-back start edge
                    if (w_commit) begin
                        r_state    <= w_stop_fail ? ST_WAIT_IDLE : ST_IDLE;
                        r_idle_cnt <= '0;
                    end else if (w_sample_valid && !w_vote) begin
                        r_stop_bad <= 1'b1;
                    end else if (w_bit_end) begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!w_rx_s) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == c_CNT_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + c_CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_receive_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_uart_receive_param
// Brief  : Scoreboard bench for uart_receive_param (default and 7N2/16 builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_receive_param;

    localparam int CPB  = 20;
    localparam int CPB2 = 16;

    logic       clk         = 1'b0;
    logic       reset       = 1'b0;
    logic       rx          = 1'b1;
    logic       rx2         = 1'b1;
    logic       reset_ready = 1'b0;
    logic       ack2        = 1'b0;

    logic [7:0] data;
    logic       ready, parity_err, frame_err, overrun, busy;
    logic [6:0] data2;
    logic       ready2, perr2, ferr2, ovr2, busy2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic sb_en    = 1'b0;
    logic mon_prev = 1'b0;

    always #10 clk = ~clk;

    uart_receive_param dut (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx),
        .data        (data),
        .ready       (ready),
        .reset_ready (reset_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    uart_receive_param #(
        .CLKS_PER_BIT (CPB2),
        .DATA_BITS    (7),
        .PARITY       (0),
        .STOP_BITS    (2)
    ) dut2 (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx2),
        .data        (data2),
        .ready       (ready2),
        .reset_ready (ack2),
        .parity_err  (perr2),
        .frame_err   (ferr2),
        .overrun     (ovr2),
        .busy        (busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rising edge of ready is one commit
    always @(negedge clk) begin
        if (sb_en && ready && !mon_prev) begin
            check("commit_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sb_data", data, mon_e.d);
                check("sb_parity_err", parity_err, mon_e.pe);
                check("sb_frame_err", frame_err, mon_e.fe);
                check("sb_overrun", overrun, 0);
            end
        end
        mon_prev = ready;
    end

    task automatic drive_bit(input bit sel, input logic v, input int cpb, input bit spike);
        if (sel) rx2 = v; else rx = v;
        if (spike) begin
            repeat (cpb / 2) @(negedge clk);
            if (sel) rx2 = ~v; else rx = ~v;
            @(negedge clk);
            if (sel) rx2 = v; else rx = v;
            repeat (cpb / 2 - 1) @(negedge clk);
        end else begin
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic send_frame(input bit sel, input int cpb, input int nbits, input logic [8:0] d,
                              input int par_mode, input bit par_flip, input int nstop,
                              input logic stop_val, input int spike_bit);
        logic p;
        p = 1'b0;
        drive_bit(sel, 1'b0, cpb, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(sel, d[i], cpb, i == spike_bit);
            p = p ^ d[i];
        end
        if (par_mode != 0) begin
            if (par_mode == 2) p = ~p;
            drive_bit(sel, p ^ par_flip, cpb, 1'b0);
        end
        for (int s = 0; s < nstop; s++) drive_bit(sel, stop_val, cpb, 1'b0);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        exp_q.push_back(e);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic ack_frame(input string tag);
        int n;
        n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_seen"}, ready, 1);
        if (ready) begin
            repeat (5) @(negedge clk);
            reset_ready = 1'b1;
            @(negedge clk);
            reset_ready = 1'b0;
            @(negedge clk);
            check({tag, "_ack_clears"}, ready, 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_ready", ready, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        idle_bits(2);

        // Back-to-back frames, each acknowledged
        sb_en = 1'b1;
        push_exp(8'h1D, 0, 0);
        push_exp(8'hE2, 0, 0);
        push_exp(8'hFF, 0, 0);
        fork
            begin
                send_frame(0, CPB, 8, 9'h01D, 1, 0, 1, 1'b1, -1);
                send_frame(0, CPB, 8, 9'h0E2, 1, 0, 1, 1'b1, -1);
                send_frame(0, CPB, 8, 9'h0FF, 1, 0, 1, 1'b1, -1);
            end
            begin
                ack_frame("t1a");
                ack_frame("t1b");
                ack_frame("t1c");
            end
        join
        idle_bits(2);

        // Same stream without acks
        sb_en = 1'b0;
        send_frame(0, CPB, 8, 9'h01D, 1, 0, 1, 1'b1, -1);
        check("t2_data1", data, 8'h1D);
        check("t2_ready1", ready, 1);
        check("t2_overrun1", overrun, 0);
        send_frame(0, CPB, 8, 9'h0E2, 1, 0, 1, 1'b1, -1);
        check("t2_data2", data, 8'hE2);
        check("t2_overrun2", overrun, 1);
        send_frame(0, CPB, 8, 9'h0FF, 1, 0, 1, 1'b1, -1);
        check("t2_data3", data, 8'hFF);
        check("t2_ready3", ready, 1);
        check("t2_overrun3", overrun, 1);
        reset_ready = 1'b1;
        @(negedge clk);
        reset_ready = 1'b0;
        check("t2_ack_ready", ready, 0);
        check("t2_ack_overrun", overrun, 0);
        check("t2_ack_keeps_data", data, 8'hFF);
        idle_bits(2);

        // Parity error, then a clean frame clears it
        sb_en = 1'b1;
        push_exp(8'h1D, 1, 0);
        send_frame(0, CPB, 8, 9'h01D, 1, 1, 1, 1'b1, -1);
        ack_frame("t3a");
        push_exp(8'hE2, 0, 0);
        send_frame(0, CPB, 8, 9'h0E2, 1, 0, 1, 1'b1, -1);
        ack_frame("t3b");
        idle_bits(2);

        // Stop bit low, line held low for 2000 ns
        push_exp(8'h1D, 0, 1);
        send_frame(0, CPB, 8, 9'h01D, 1, 0, 1, 1'b0, -1);
        ack_frame("t4");
        repeat (90) @(negedge clk);
        check("t4_busy_low", busy, 1);
        rx = 1'b1;
        repeat (19) @(negedge clk);
        check("t4_busy_380", busy, 1);
        repeat (5) @(negedge clk);
        check("t4_busy_480", busy, 0);
        check("t4_no_extra_commit", ready, 0);
        idle_bits(2);

        // 60 ns glitch on idle line
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_glitch_busy", busy, 1);
        repeat (10) @(negedge clk);
        check("t5_glitch_idle", busy, 0);
        check("t5_glitch_ready", ready, 0);
        idle_bits(1);

        // 20 ns spike inside data bit 1
        push_exp(8'hE2, 0, 0);
        send_frame(0, CPB, 8, 9'h0E2, 1, 0, 1, 1'b1, 1);
        ack_frame("t5s");
        idle_bits(2);

        // Reset mid-DATA, then a full frame
        drive_bit(0, 1'b0, CPB, 1'b0);
        drive_bit(0, 1'b1, CPB, 1'b0);
        drive_bit(0, 1'b0, CPB, 1'b0);
        drive_bit(0, 1'b1, CPB, 1'b0);
        check("t6_busy_mid", busy, 1);
        reset = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check("t6_rst_data", data, 0);
        check("t6_rst_ready", ready, 0);
        check("t6_rst_flags", {parity_err, frame_err, overrun}, 0);
        check("t6_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        idle_bits(2);
        push_exp(8'hA5, 0, 0);
        send_frame(0, CPB, 8, 9'h0A5, 1, 0, 1, 1'b1, -1);
        ack_frame("t6r");

        // 7N2 at 16 clk/bit
        send_frame(1, CPB2, 7, 9'h055, 0, 0, 2, 1'b1, -1);
        check("t6_p_ready", ready2, 1);
        check("t6_p_data", data2, 7'h55);
        check("t6_p_parity_err", perr2, 0);
        check("t6_p_frame_err", ferr2, 0);
        idle_bits(2);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
